// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: opALU classes, R-type funct codes,
// 4-bit ALU op codes, FSM state encoding and the opALU/funct decoder.
package alu_pkg;

  localparam logic [2:0] OPALU_ADD   = 3'b000;
  localparam logic [2:0] OPALU_SUB   = 3'b001;
  localparam logic [2:0] OPALU_RTYPE = 3'b010;
  localparam logic [2:0] OPALU_AND   = 3'b011;
  localparam logic [2:0] OPALU_SLT   = 3'b100;
  localparam logic [2:0] OPALU_OR    = 3'b111;

  localparam logic [5:0] FUNCT_NOP = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_MUL = 6'b011001;
  localparam logic [5:0] FUNCT_DIV = 6'b011010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b0111;
  localparam logic [3:0] OP_SLT = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic [3:0] op;
    logic       illegal;
  } alu_dec_t;

  // Illegal encodings decode to NOP with the illegal flag set.
  function automatic alu_dec_t decode_op(input logic [2:0] op_alu, input logic [5:0] funct);
    alu_dec_t d;
    d.op      = OP_NOP;
    d.illegal = 1'b0;
    case (op_alu)
      OPALU_ADD: d.op = OP_ADD;
      OPALU_SUB: d.op = OP_SUB;
      OPALU_AND: d.op = OP_AND;
      OPALU_SLT: d.op = OP_SLT;
      OPALU_OR:  d.op = OP_OR;
      OPALU_RTYPE: begin
        case (funct)
          FUNCT_NOP: d.op = OP_NOP;
          FUNCT_ADD: d.op = OP_ADD;
          FUNCT_SUB: d.op = OP_SUB;
          FUNCT_MUL: d.op = OP_MUL;
          FUNCT_DIV: d.op = OP_DIV;
          FUNCT_AND: d.op = OP_AND;
          FUNCT_OR:  d.op = OP_OR;
          FUNCT_NOR: d.op = OP_NOR;
          FUNCT_XOR: d.op = OP_XOR;
          FUNCT_SLT: d.op = OP_SLT;
          default:   d.illegal = 1'b1;
        endcase
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one set
// of registers; WIDTH step cycles after start, done/res valid during the last step.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  // r_acc: product accumulator or partial remainder.
  // r_x:   multiplicand (shifts left) or dividend/quotient shift register.
  // r_y:   multiplier (shifts right) or divisor.
  logic             r_busy;
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;

  logic [WIDTH-1:0] w_mul_acc;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  always_comb begin
    w_mul_acc = r_acc + (r_y[0] ? r_x : '0);
    w_shift   = {r_acc, r_x[WIDTH-1]};
    w_diff    = w_shift - {1'b0, r_y};
    w_fits    = ~w_diff[WIDTH];
    w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    w_quo_nxt = {r_x[WIDTH-2:0], w_fits};
  end

  assign done = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
  assign res  = r_is_div ? w_quo_nxt : w_mul_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= '0;
      r_y      <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_is_div <= is_div;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_x      <= a;
      r_y      <= b;
    end else if (r_busy) begin
      if (r_is_div) begin
        r_acc <= w_rem_nxt;
        r_x   <= w_quo_nxt;
      end else begin
        r_acc <= w_mul_acc;
        r_x   <= {r_x[WIDTH-2:0], 1'b0};
        r_y   <= {1'b0, r_y[WIDTH-1:1]};
      end
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_exec_seq.sv
// Execute-stage ALU: decode, single-cycle datapath, IDLE/MUL/DIV sequencer and
// registered outputs. Handshake: accept = in_valid & in_ready; out_valid is a 1-cycle pulse, no backpressure.
module alu_exec_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opALU,
  input  logic [5:0]       opFunction,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_op,
  output logic             div_by_zero,
  output logic             illegal_op,
  output alu_state_e       dbg_state
);

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_alu_op;
  logic             r_div_by_zero;
  logic             r_illegal_op;

  alu_dec_t         w_dec;
  logic             w_accept;
  logic [WIDTH-1:0] w_fast_res;
  logic             w_fast_dbz;
  logic             w_md_start;
  logic             w_md_is_div;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_res;
  logic             w_load;
  logic [WIDTH-1:0] w_load_res;
  logic [3:0]       w_load_op;
  logic             w_load_dbz;
  logic             w_load_ill;

  assign w_dec    = decode_op(opALU, opFunction);
  assign in_ready = (r_state == ST_IDLE);
  assign w_accept = in_valid & in_ready;

  // The DIV arm is only used when b==0; non-zero divisors go to the sequencer.
  always_comb begin
    w_fast_res = '0;
    w_fast_dbz = 1'b0;
    case (w_dec.op)
      OP_ADD: w_fast_res = a + b;
      OP_SUB: w_fast_res = a - b;
      OP_AND: w_fast_res = a & b;
      OP_OR:  w_fast_res = a | b;
      OP_NOR: w_fast_res = ~(a | b);
      OP_XOR: w_fast_res = a ^ b;
      OP_SLT: w_fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_DIV: begin
        w_fast_res = '1;
        w_fast_dbz = 1'b1;
      end
      default: w_fast_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_md_start),
    .is_div (w_md_is_div),
    .a      (a),
    .b      (b),
    .done   (w_md_done),
    .res    (w_md_res)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_md_start  = 1'b0;
    w_md_is_div = 1'b0;
    w_load      = 1'b0;
    w_load_res  = w_fast_res;
    w_load_op   = w_dec.op;
    w_load_dbz  = w_fast_dbz;
    w_load_ill  = w_dec.illegal;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_dec.op == OP_MUL) begin
            w_state_nxt = ST_MUL;
            w_md_start  = 1'b1;
          end else if ((w_dec.op == OP_DIV) && (b != '0)) begin
            w_state_nxt = ST_DIV;
            w_md_start  = 1'b1;
            w_md_is_div = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (w_md_done) begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
          w_load_res  = w_md_res;
          w_load_op   = (r_state == ST_MUL) ? OP_MUL : OP_DIV;
          w_load_dbz  = 1'b0;
          w_load_ill  = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_alu_op      <= OP_NOP;
      r_div_by_zero <= 1'b0;
      r_illegal_op  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_load;
      if (w_load) begin
        r_result      <= w_load_res;
        r_alu_op      <= w_load_op;
        r_div_by_zero <= w_load_dbz;
        r_illegal_op  <= w_load_ill;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign alu_op      = r_alu_op;
  assign div_by_zero = r_div_by_zero;
  assign illegal_op  = r_illegal_op;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq (WIDTH=32): back-to-back single-cycle vector table,
// then hand-written MUL/DIV, held-in_valid, and mid-operation reset sequences.
module tb_alu_exec_seq;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opALU;
  logic [5:0]    opFunction;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic [W-1:0]  result;
  logic [3:0]    alu_op;
  logic          div_by_zero;
  logic          illegal_op;
  logic [1:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]   opalu;
    logic [5:0]   funct;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   op;
    logic         dbz;
    logic         ill;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  alu_exec_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .opALU       (opALU),
    .opFunction  (opFunction),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .result      (result),
    .alu_op      (alu_op),
    .div_by_zero (div_by_zero),
    .illegal_op  (illegal_op),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: one R-type multi-cycle op, optionally keeping in_valid high while busy
  task automatic run_long(input string name, input logic [5:0] funct, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] exp_res,
                          input logic [3:0] exp_op, input logic [1:0] exp_state, input bit hold);
    int lat;
    int low;
    @(negedge clk);
    in_valid = 1'b1; opALU = 3'b010; opFunction = funct; a = av; b = bv;
    @(posedge clk); #1;
    if (hold) opFunction = 6'b100000;
    else in_valid = 1'b0;
    a = $urandom; b = $urandom;
    chk({name, " busy state"}, {30'd0, dbg_state}, {30'd0, exp_state});
    lat = 1; low = 0;
    while (!out_valid && lat < 100) begin
      if (!in_ready) low++;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({name, " latency"}, lat, 33);
    chk({name, " in_ready low cycles"}, low, 32);
    chk({name, " result"}, result, exp_res);
    chk({name, " alu_op"}, {28'd0, alu_op}, {28'd0, exp_op});
    chk({name, " div_by_zero"}, {31'd0, div_by_zero}, 0);
    chk({name, " illegal_op"}, {31'd0, illegal_op}, 0);
    chk({name, " in_ready at done"}, {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    chk({name, " single pulse"}, {31'd0, out_valid}, 0);
    chk({name, " result hold"}, result, exp_res);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; in_valid = 1'b0; opALU = '0; opFunction = '0; a = '0; b = '0;

    // 1-cycle vector table: {opALU, funct, a, b, result, alu_op, dbz, ill}
    vecs[0]  = '{3'b010, 6'b100000, 32'd5,        32'd7,        32'd12,       4'b0001, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 6'b011001, 32'hFFFFFFFF, 32'd2,        32'd1,        4'b0001, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 6'b000000, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0010, 1'b0, 1'b0};
    vecs[3]  = '{3'b010, 6'b100010, 32'd100,      32'd1,        32'd99,       4'b0010, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 6'b000000, 32'hFFFFFFFF, 32'd1,        32'd1,        4'b1000, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 6'b101010, 32'd5,        32'hFFFFFFFF, 32'd0,        4'b1000, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 32'd1,        4'b1000, 1'b0, 1'b0};
    vecs[7]  = '{3'b100, 6'b000000, 32'd7,        32'd7,        32'd0,        4'b1000, 1'b0, 1'b0};
    vecs[8]  = '{3'b111, 6'b000000, 32'hF0,       32'h0F,       32'hFF,       4'b0110, 1'b0, 1'b0};
    vecs[9]  = '{3'b011, 6'b000000, 32'hF0,       32'h3C,       32'h30,       4'b0101, 1'b0, 1'b0};
    vecs[10] = '{3'b010, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b0101, 1'b0, 1'b0};
    vecs[11] = '{3'b010, 6'b100101, 32'h12,       32'h21,       32'h33,       4'b0110, 1'b0, 1'b0};
    vecs[12] = '{3'b010, 6'b100111, 32'd0,        32'd0,        32'hFFFFFFFF, 4'b0111, 1'b0, 1'b0};
    vecs[13] = '{3'b010, 6'b100111, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 4'b0111, 1'b0, 1'b0};
    vecs[14] = '{3'b010, 6'b100110, 32'hFF00FF00, 32'hFFFF0000, 32'h00FFFF00, 4'b1001, 1'b0, 1'b0};
    vecs[15] = '{3'b010, 6'b000000, 32'd5,        32'd7,        32'd0,        4'b0000, 1'b0, 1'b0};
    vecs[16] = '{3'b101, 6'b100000, 32'd5,        32'd7,        32'd0,        4'b0000, 1'b0, 1'b1};
    vecs[17] = '{3'b110, 6'b100000, 32'd5,        32'd7,        32'd0,        4'b0000, 1'b0, 1'b1};
    vecs[18] = '{3'b010, 6'b111111, 32'd5,        32'd7,        32'd0,        4'b0000, 1'b0, 1'b1};
    vecs[19] = '{3'b010, 6'b011010, 32'd9,        32'd0,        32'hFFFFFFFF, 4'b0100, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    chk("reset in_ready", {31'd0, in_ready}, 1);
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset result", result, 0);
    chk("reset alu_op", {28'd0, alu_op}, 0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 0);
    chk("reset illegal_op", {31'd0, illegal_op}, 0);
    chk("reset state", {30'd0, dbg_state}, 0);

    // back-to-back single-cycle ops, one accept per cycle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; opALU = vecs[i].opalu; opFunction = vecs[i].funct;
      a = vecs[i].a; b = vecs[i].b;
      exp_q.push_back(vecs[i].res);
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 1);
      chk($sformatf("vec%0d result", i), result, exp_q.pop_front());
      chk($sformatf("vec%0d alu_op", i), {28'd0, alu_op}, {28'd0, vecs[i].op});
      chk($sformatf("vec%0d div_by_zero", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      chk($sformatf("vec%0d illegal_op", i), {31'd0, illegal_op}, {31'd0, vecs[i].ill});
      chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 1);
    end
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle out_valid", {31'd0, out_valid}, 0);
    chk("idle result hold", result, 32'hFFFFFFFF);

    run_long("mul 6x7 held", 6'b011001, 32'd6, 32'd7, 32'd42, 4'b0011, 2'd1, 1'b1);
    run_long("mul ffffffff sq", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 4'b0011, 2'd1, 1'b0);
    run_long("mul 12345x100", 6'b011001, 32'h12345, 32'h100, 32'h1234500, 4'b0011, 2'd1, 1'b0);
    run_long("div 100/7", 6'b011010, 32'd100, 32'd7, 32'd14, 4'b0100, 2'd2, 1'b0);
    run_long("div ffffffff/1", 6'b011010, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 4'b0100, 2'd2, 1'b0);
    run_long("div 5/9", 6'b011010, 32'd5, 32'd9, 32'd0, 4'b0100, 2'd2, 1'b1);

    // divide by zero right after a sequenced op
    @(negedge clk);
    in_valid = 1'b1; opALU = 3'b010; opFunction = 6'b011010; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("div0 out_valid", {31'd0, out_valid}, 1);
    chk("div0 result", result, 32'hFFFFFFFF);
    chk("div0 flag", {31'd0, div_by_zero}, 1);
    chk("div0 alu_op", {28'd0, alu_op}, 4'b0100);

    // reset in the middle of a multiply
    @(negedge clk);
    in_valid = 1'b1; opALU = 3'b010; opFunction = 6'b011001; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort out_valid", {31'd0, out_valid}, 0);
    chk("abort in_ready", {31'd0, in_ready}, 1);
    chk("abort result", result, 0);
    chk("abort state", {30'd0, dbg_state}, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("abort no late pulse", pulses, 0);
    @(negedge clk);
    in_valid = 1'b1; opALU = 3'b000; opFunction = 6'b000000; a = 32'd20; b = 32'd22;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post-reset add valid", {31'd0, out_valid}, 1);
    chk("post-reset add result", result, 32'd42);
    chk("post-reset add alu_op", {28'd0, alu_op}, 4'b0001);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
